// File: rtl/quad_enc_gen.sv
// Quadrature rotary-encoder emulator: plays signed detent commands out as ck/dt Gray-code phases.
// Optional abort input is compiled in when QUAD_ENC_ABORT_EN is defined.
module quad_enc_gen #(
    parameter int PHASE_CYCLES = 1000,
    parameter int STEP_WIDTH   = 8
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic signed [STEP_WIDTH-1:0] cmd_steps,
    input  logic                         cmd_valid,
`ifdef QUAD_ENC_ABORT_EN
    input  logic                         abort,
`endif
    output logic                         cmd_ready,
    output logic                         ck,
    output logic                         dt,
    output logic                         busy,
    output logic                         done,
    output logic [STEP_WIDTH-1:0]        steps_done
);

    localparam logic [15:0] LAST = 16'(PHASE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t                 state, state_nxt;
    logic [STEP_WIDTH-1:0]  mag, mag_nxt, steps_nxt, cmd_mag;
    logic                   ccw, ccw_nxt;
    logic                   lead, lead_nxt;
    logic                   abort_req, abort_req_nxt;
    logic                   abort_in;
    logic [1:0]             pos, pos_nxt;
    logic [15:0]            cnt, cnt_nxt;
    logic                   ck_nxt, dt_nxt;

`ifdef QUAD_ENC_ABORT_EN
    assign abort_in = abort;
`else
    assign abort_in = 1'b0;
`endif

    // -128 maps to 128 because the result is read as unsigned.
    function automatic logic [STEP_WIDTH-1:0] magnitude(input logic signed [STEP_WIDTH-1:0] x);
        logic [STEP_WIDTH-1:0] u;
        u = $unsigned(x);
        return u[STEP_WIDTH-1] ? (~u + STEP_WIDTH'(1)) : u;
    endfunction

    // pos 0..3 walks 01,00,10,11 clockwise; counter-clockwise swaps the channels.
    function automatic logic [1:0] phase_level(input logic [1:0] p, input logic rev);
        logic a, b;
        a = p[1];
        b = ~(p[1] ^ p[0]);
        return rev ? {b, a} : {a, b};
    endfunction

    assign cmd_mag   = magnitude(cmd_steps);
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == FINISH);

    always_comb begin
        state_nxt     = state;
        mag_nxt       = mag;
        ccw_nxt       = ccw;
        lead_nxt      = lead;
        abort_req_nxt = abort_req;
        pos_nxt       = pos;
        cnt_nxt       = cnt;
        steps_nxt     = steps_done;
        ck_nxt        = ck;
        dt_nxt        = dt;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    ccw_nxt       = cmd_steps[STEP_WIDTH-1];
                    mag_nxt       = cmd_mag;
                    steps_nxt     = '0;
                    abort_req_nxt = 1'b0;
                    if (cmd_mag == '0) begin
                        state_nxt = FINISH;
                    end else begin
                        // Pretend the rest phase just expired so the next edge drives phase 0.
                        state_nxt = RUN;
                        lead_nxt  = 1'b1;
                        pos_nxt   = 2'd3;
                        cnt_nxt   = LAST;
                    end
                end
            end
            RUN: begin
                if (abort_in) abort_req_nxt = 1'b1;
                if (cnt == LAST) begin
                    cnt_nxt = '0;
                    pos_nxt = pos + 2'd1;
                    if (pos == 2'd3) begin
                        if (lead) begin
                            lead_nxt = 1'b0;
                        end else begin
                            steps_nxt = steps_done + STEP_WIDTH'(1);
                            if (steps_nxt == mag || abort_req || abort_in) begin
                                state_nxt = FINISH;
                                pos_nxt   = 2'd3;
                            end
                        end
                    end
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
                {ck_nxt, dt_nxt} = phase_level(pos_nxt, ccw);
            end
            FINISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state      <= IDLE;
            ck         <= 1'b1;
            dt         <= 1'b1;
            steps_done <= '0;
            cnt        <= '0;
            pos        <= 2'd3;
            lead       <= 1'b0;
            abort_req  <= 1'b0;
        end else begin
            state      <= state_nxt;
            ck         <= ck_nxt;
            dt         <= dt_nxt;
            steps_done <= steps_nxt;
            cnt        <= cnt_nxt;
            pos        <= pos_nxt;
            lead       <= lead_nxt;
            abort_req  <= abort_req_nxt;
        end
    end

    // Command operands need no reset: they are always loaded on acceptance before use.
    always_ff @(posedge aclk) begin
        mag <= mag_nxt;
        ccw <= ccw_nxt;
    end

endmodule

// File: doc/quad_enc_gen.md
QUAD_ENC_GEN -- requirements
Module: quad_enc_gen

Interface
REQ-001 SHALL have parameter PHASE_CYCLES, default 1000, meaning aclk cycles each quadrature phase is held (legal range 2..65535).
REQ-002 SHALL have parameter STEP_WIDTH, default 8, meaning width of the signed step command.
REQ-003 SHALL have port aclk, input, 1, meaning the single system clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port aresetn, input, 1, meaning synchronous active-low reset.
REQ-005 SHALL have port cmd_steps, input, STEP_WIDTH, meaning signed detent count; positive is clockwise, negative is counter-clockwise.
REQ-006 SHALL have port cmd_valid, input, 1, meaning cmd_steps is valid.
REQ-007 SHALL have port cmd_ready, output, 1, meaning the block can accept a command.
REQ-008 SHALL have port ck, output, 1, meaning emulated encoder channel A (rest level 1).
REQ-009 SHALL have port dt, output, 1, meaning emulated encoder channel B (rest level 1).
REQ-010 SHALL have port busy, output, 1, meaning a command is executing.
REQ-011 SHALL have port done, output, 1, meaning a one-cycle pulse on command completion.
REQ-012 SHALL have port steps_done, output, STEP_WIDTH, meaning unsigned count of detents completed in the current or last command.

Function
REQ-013 SHALL implement states IDLE, RUN and FINISH; cmd_ready is high only in IDLE.
REQ-014 SHALL accept a command on an edge where cmd_valid and cmd_ready are both high, latch the sign and the magnitude |cmd_steps| as STEP_WIDTH-bit unsigned (-128 becomes 128), and clear steps_done.
REQ-015 SHALL on acceptance with magnitude 0 go to FINISH with no ck/dt edge.
REQ-016 SHALL on acceptance with nonzero magnitude enter RUN and drive the first phase on the next edge.
REQ-017 SHALL sequence (ck,dt) for a clockwise detent as 11->01->00->10->11, and for a counter-clockwise detent as 11->10->00->01->11.
REQ-018 SHALL change at most one of ck/dt per transition.
REQ-019 SHALL hold each of the four phases per detent, including the final 11, for exactly PHASE_CYCLES cycles, so one detent takes 4*PHASE_CYCLES cycles.
REQ-020 SHALL increment steps_done on the cycle the final 11 phase of a detent expires, then start the next detent or go to FINISH when steps_done equals the magnitude.
REQ-021 SHALL in FINISH pulse done for one cycle, return to IDLE on the next edge, and hold steps_done until the next acceptance.
REQ-022 SHALL hold busy high in RUN and FINISH and low in IDLE.
REQ-023 SHALL ignore cmd_valid outside IDLE and SHALL NOT change cmd_steps handling mid-command.
REQ-024 SHALL register ck and dt directly from flops, glitch-free.

Reset
REQ-025 SHALL while aresetn is low on an edge set state IDLE, ck=1, dt=1, cmd_ready=1, busy=0, done=0, steps_done=0, and clear the phase counter.
REQ-026 SHALL on reset during RUN drop the partial detent immediately, leave steps_done unincremented, and emit no done pulse.

Configuration
REQ-027 SHALL with macro QUAD_ENC_ABORT_EN defined add input port abort (1 bit); abort high in RUN completes the current detent back to 11 (including its final hold), counts it, then enters FINISH with done pulsed.
REQ-028 SHALL treat abort as ignored when sampled in IDLE or FINISH.
REQ-029 SHALL with QUAD_ENC_ABORT_EN undefined have no abort port and always execute commands to completion.

Verification (PHASE_CYCLES=4)
REQ-030 SHALL test cmd_steps=+2: ck/dt go 11->01->00->10->11 twice, each level held 4 cycles; done pulses once after 32 cycles; steps_done=2.
REQ-031 SHALL test cmd_steps=-1: sequence 11->10->00->01->11; done after 16 cycles; steps_done=1.
REQ-032 SHALL test cmd_steps=0: no ck/dt edge; done pulses within 2 cycles of acceptance; steps_done=0.
REQ-033 SHALL test cmd_steps=-128: 128 CCW detents; steps_done=128; cmd_valid pulses during RUN are ignored.
REQ-034 SHALL test aresetn low for 1 cycle during 00 phase: next cycle ck=dt=1, cmd_ready=1, no done pulse.
REQ-035 SHALL test, with QUAD_ENC_ABORT_EN defined, +5 with abort in detent 2 phase 01: detent 2 completes, done pulses, steps_done=2.
